// File: rtl/booth_seq_ctrl.sv
// booth_seq_ctrl: sequencing controller for a radix-2 Booth multiplier datapath.
// Steps the A/Q/M registers through WIDTH Booth iterations. Each iteration has
// an ARITH cycle (add/sub decided from {q0,qm1}) and a SHIFT cycle.
// A start/busy/done handshake faces the system.
// Optional build macro: BOOTH_SEQ_SKIP_EN. When it is defined, a no-op iteration
// (q0 == qm1) shifts directly from ARITH and does not visit SHIFT.
// CNT_W must satisfy 2**CNT_W > WIDTH so that iter can hold WIDTH.
module booth_seq_ctrl #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             q0,
    input  logic             qm1,
    output logic             ld_m,
    output logic             ld_q,
    output logic             clr_a,
    output logic             clr_qm1,
    output logic             add_en,
    output logic             sub_en,
    output logic             shift,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] iter
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ARITH = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] ITER_INIT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] ITER_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] ITER_ZERO = '0;

    state_t state;
    logic   load_r;     // single flop behind all four LOAD strobes
    logic   shift_r;    // registered shift strobe for the SHIFT state
    logic   in_arith;
    logic   skip_now;   // ARITH no-op iteration that shifts in place

    assign in_arith = (state == ARITH);

`ifdef BOOTH_SEQ_SKIP_EN
    assign skip_now = in_arith && (q0 == qm1);
`else
    assign skip_now = 1'b0;
`endif

    assign ld_m    = load_r;
    assign ld_q    = load_r;
    assign clr_a   = load_r;
    assign clr_qm1 = load_r;
    assign shift   = shift_r | skip_now;

    // Booth decode of the current Q[0]/Q[-1] pair; only live in ARITH
    always_comb begin
        add_en = 1'b0;
        sub_en = 1'b0;
        if (in_arith) begin
            case ({q0, qm1})
                2'b10:   sub_en = 1'b1;
                2'b01:   add_en = 1'b1;
                default: begin
                    add_en = 1'b0;
                    sub_en = 1'b0;
                end
            endcase
        end
    end

    // Sequencer: state, iteration count and registered Moore strobes for the next state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            iter    <= ITER_ZERO;
            load_r  <= 1'b0;
            shift_r <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            load_r  <= 1'b0;
            shift_r <= 1'b0;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (start) begin
                        state  <= LOAD;
                        load_r <= 1'b1;
                        busy   <= 1'b1;
                    end
                end
                LOAD: begin
                    state <= ARITH;
                    iter  <= ITER_INIT;
                    busy  <= 1'b1;
                end
                ARITH: begin
                    busy <= 1'b1;
                    if (skip_now) begin
                        // No-op iteration: the shift happens this cycle, so count it here
                        if (iter != ITER_ZERO) begin
                            iter <= iter - ITER_ONE;
                        end
                        if (iter == ITER_ONE) begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end
                    end else begin
                        state   <= SHIFT;
                        shift_r <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (iter != ITER_ZERO) begin
                        iter <= iter - ITER_ONE;
                    end
                    if (iter == ITER_ONE) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        state <= ARITH;
                        busy  <= 1'b1;
                    end
                end
                DONE: begin
                    // start is deliberately not looked at here; a new request must arrive in IDLE
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// tb_booth_seq_ctrl: bench for booth_seq_ctrl with a behavioural A/Q/M datapath
// and a scoreboard of expected products and latencies.
module tb_booth_seq_ctrl;

    localparam int W  = 16;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          q0, qm1;
    logic          ld_m, ld_q, clr_a, clr_qm1, add_en, sub_en, shift, busy, done;
    logic [CW-1:0] iter;

    // behavioural datapath driven by the strobes
    logic signed [W-1:0] mcand = '0;
    logic signed [W-1:0] mplier = '0;
    logic [W-1:0]        dp_a, dp_q, dp_m;
    logic                dp_qm1;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    // monitor counters
    int n_shift, n_add, n_sub, n_busy, n_done, n_load, excl_err, alt_err, last_op;

    // scoreboard
    logic [2*W-1:0] exp_prod[$];
    int             exp_lat[$];

    booth_seq_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .q0(q0), .qm1(qm1),
        .ld_m(ld_m), .ld_q(ld_q), .clr_a(clr_a), .clr_qm1(clr_qm1),
        .add_en(add_en), .sub_en(sub_en), .shift(shift),
        .busy(busy), .done(done), .iter(iter)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign q0  = dp_q[0];
    assign qm1 = dp_qm1;

    always @(posedge clk) begin
        if (ld_m)    dp_m   <= mcand;
        if (ld_q)    dp_q   <= mplier;
        if (clr_a)   dp_a   <= '0;
        if (clr_qm1) dp_qm1 <= 1'b0;
        if (add_en)  dp_a   <= dp_a + dp_m;
        if (sub_en)  dp_a   <= dp_a - dp_m;
        if (shift)   {dp_a, dp_q, dp_qm1} <= {dp_a[W-1], dp_a, dp_q};
    end

    always @(negedge clk) begin
        logic [3:0] ldg;
        int         op;
        if (reset === 1'b1) begin
            ldg = {ld_m, ld_q, clr_a, clr_qm1};
            if (shift)  n_shift++;
            if (add_en) n_add++;
            if (sub_en) n_sub++;
            if (busy)   n_busy++;
            if (done)   n_done++;
            if (ld_m)   n_load++;
            if ((ldg != 4'h0 && ldg != 4'hF) || (add_en && sub_en) ||
                (shift && (add_en || sub_en)) ||
                (ldg != 4'h0 && (add_en || sub_en || shift)) ||
                ((add_en || sub_en || shift || ldg != 4'h0) && !busy) ||
                (done && busy))
                excl_err++;
            if (add_en || sub_en) begin
                op = add_en ? 1 : 2;
                if (op == last_op) alt_err++;
                last_op = op;
            end
        end
    end

    // expected cycles from start edge to the cycle done is high
    function automatic int exp_latency(input logic [W-1:0] m);
`ifdef BOOTH_SEQ_SKIP_EN
        int   n = 0;
        logic prev = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (m[i] != prev) n++;
            prev = m[i];
        end
        return 1 + W + n;
`else
        return 2 * W + 1;
`endif
    endfunction

    // Booth recoding of the multiplier: pair (m[i], m[i-1]) = 10 -> sub, 01 -> add
    function automatic int count_ops(input logic [W-1:0] m, input bit want_add);
        int   n = 0;
        logic prev = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (want_add && !m[i] && prev) n++;
            if (!want_add && m[i] && !prev) n++;
            prev = m[i];
        end
        return n;
    endfunction

    function automatic logic [2*W-1:0] ref_prod(input logic signed [W-1:0] a,
                                                input logic signed [W-1:0] b);
        longint p;
        p = longint'(a) * longint'(b);
        return p[2*W-1:0];
    endfunction

    task automatic clear_counts();
        @(negedge clk);
        #1;
        n_shift = 0; n_add = 0; n_sub = 0; n_busy = 0; n_done = 0;
        n_load = 0; excl_err = 0; alt_err = 0; last_op = 0;
    endtask

    task automatic start_pulse(output int t0);
        @(negedge clk);
        start = 1'b1;
        t0 = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int td, output bit ok);
        ok = 1'b0;
        td = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                td = cyc;
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bit found;
        int t0;
        logic [9+CW-1:0] outs;
        repeat (3) @(negedge clk);
        outs = {ld_m, ld_q, clr_a, clr_qm1, add_en, sub_en, shift, busy, done, iter};
        n_checks++;
        if (outs !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want 0", outs);
        end
        reset = 1'b1;
        mcand = 16'sd100;
        mplier = 16'h5555;
        clear_counts();
        start_pulse(t0);
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy && !ld_m && !shift && iter == CW'(5)) begin
                found = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL reset_reach_iter5: got timeout want ARITH at iter 5");
        end else begin
            n_checks++;
            if ((add_en ^ sub_en) !== 1'b1) begin
                n_fail++;
                $display("FAIL pre_reset_strobe: got add=%b sub=%b want one high", add_en, sub_en);
            end
            reset = 1'b0;
            #1;
            outs = {ld_m, ld_q, clr_a, clr_qm1, add_en, sub_en, shift, busy, done, iter};
            n_checks++;
            if (outs !== '0) begin
                n_fail++;
                $display("FAIL async_reset_outputs: got %h want 0", outs);
            end
        end
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        repeat (5) @(negedge clk);
        outs = {ld_m, ld_q, clr_a, clr_qm1, add_en, sub_en, shift, busy, done, iter};
        n_checks++;
        if (outs !== '0) begin
            n_fail++;
            $display("FAIL post_reset_idle: got %h want 0", outs);
        end
    endtask

    task automatic test_basic();
        int t0, td, lat;
        bit ok;
        logic [2*W-1:0] ep;
        repeat (3) @(negedge clk);
        mcand = 16'sd7;
        mplier = -16'sd3;
        lat = exp_latency(mplier);
        exp_prod.push_back(32'hFFFF_FFEB);
        exp_lat.push_back(lat);
        clear_counts();
        start_pulse(t0);
        wait_done(80, td, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL basic_done_timeout: got no done want done");
        end else begin
            ep = exp_prod.pop_front();
            lat = exp_lat.pop_front();
            n_checks++;
            if ({dp_a, dp_q} !== ep) begin
                n_fail++;
                $display("FAIL basic_product: got %h want %h", {dp_a, dp_q}, ep);
            end
            n_checks++;
            if (td - t0 != lat) begin
                n_fail++;
                $display("FAIL basic_latency: got %0d want %0d", td - t0, lat);
            end
            n_checks++;
            if (n_shift != W) begin
                n_fail++;
                $display("FAIL basic_shift_count: got %0d want %0d", n_shift, W);
            end
            n_checks++;
            if (n_busy != lat) begin
                n_fail++;
                $display("FAIL basic_busy_cycles: got %0d want %0d", n_busy, lat);
            end
            n_checks++;
            if (n_add != count_ops(mplier, 1'b1) || n_sub != count_ops(mplier, 1'b0)) begin
                n_fail++;
                $display("FAIL basic_addsub: got add=%0d sub=%0d want add=%0d sub=%0d",
                         n_add, n_sub, count_ops(mplier, 1'b1), count_ops(mplier, 1'b0));
            end
            @(negedge clk);
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL basic_done_pulse: got done=%b busy=%b want 0 0", done, busy);
            end
        end
    endtask

    task automatic test_alternating();
        int t0, td, lat;
        bit ok;
        logic [2*W-1:0] ep;
        repeat (3) @(negedge clk);
        mcand = -16'sd1234;
        mplier = 16'h5555;
        lat = exp_latency(mplier);
        exp_prod.push_back(ref_prod(mcand, mplier));
        exp_lat.push_back(lat);
        clear_counts();
        start_pulse(t0);
        wait_done(80, td, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL alt_done_timeout: got no done want done");
        end else begin
            ep = exp_prod.pop_front();
            lat = exp_lat.pop_front();
            n_checks++;
            if ({dp_a, dp_q} !== ep) begin
                n_fail++;
                $display("FAIL alt_product: got %h want %h", {dp_a, dp_q}, ep);
            end
            n_checks++;
            if (td - t0 != lat) begin
                n_fail++;
                $display("FAIL alt_latency: got %0d want %0d", td - t0, lat);
            end
            n_checks++;
            if (n_add != 8 || n_sub != 8) begin
                n_fail++;
                $display("FAIL alt_addsub: got add=%0d sub=%0d want 8 8", n_add, n_sub);
            end
            n_checks++;
            if (alt_err != 0) begin
                n_fail++;
                $display("FAIL alt_sequence: got %0d repeats want 0", alt_err);
            end
            n_checks++;
            if (excl_err != 0) begin
                n_fail++;
                $display("FAIL alt_exclusive: got %0d overlaps want 0", excl_err);
            end
        end
    endtask

    task automatic test_ignore_start();
        int t0, td, lat, rel;
        bit seen;
        logic [CW-1:0] prev_iter;
        logic [CW-1:0] iters[$];
        logic [2*W-1:0] ep;
        repeat (3) @(negedge clk);
        mcand = 16'sd321;
        mplier = 16'h5555;
        lat = exp_latency(mplier);
        exp_prod.push_back(ref_prod(mcand, mplier));
        exp_lat.push_back(lat);
        clear_counts();
        prev_iter = iter;
        start_pulse(t0);
        seen = 1'b0;
        td = 0;
        for (int k = 0; k < 2 * W + 16; k++) begin
            @(negedge clk);
            rel = cyc - t0;
            if (iter !== prev_iter) begin
                iters.push_back(iter);
                prev_iter = iter;
            end
            if (done === 1'b1 && !seen) begin
                seen = 1'b1;
                td = cyc;
                ep = exp_prod.pop_front();
                lat = exp_lat.pop_front();
                n_checks++;
                if ({dp_a, dp_q} !== ep) begin
                    n_fail++;
                    $display("FAIL ign_product: got %h want %h", {dp_a, dp_q}, ep);
                end
            end
            start = (rel == 3 || rel == 20 || done === 1'b1);
        end
        start = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (!seen || td - t0 != lat) begin
            n_fail++;
            $display("FAIL ign_latency: got seen=%b lat=%0d want %0d", seen, td - t0, lat);
        end
        n_checks++;
        if (n_done != 1 || n_load != 1) begin
            n_fail++;
            $display("FAIL ign_single_op: got done=%0d load=%0d want 1 1", n_done, n_load);
        end
        n_checks++;
        if (iters.size() != W + 1) begin
            n_fail++;
            $display("FAIL ign_iter_len: got %0d want %0d", iters.size(), W + 1);
        end else begin
            for (int i = 0; i <= W; i++) begin
                n_checks++;
                if (iters[i] !== CW'(W - i)) begin
                    n_fail++;
                    $display("FAIL ign_iter_seq[%0d]: got %0d want %0d", i, iters[i], W - i);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int t0, lat, d, loads;
        int td[3];
        int low[2];
        logic [2*W-1:0] ep;
        repeat (3) @(negedge clk);
        mcand = 16'sh7FFF;
        mplier = 16'sh8000;
        lat = exp_latency(mplier);
        for (int i = 0; i < 3; i++) begin
            exp_prod.push_back(32'hC000_8000);
            exp_lat.push_back(lat);
        end
        clear_counts();
        d = 0; loads = 0; low[0] = 0; low[1] = 0;
        td[0] = 0; td[1] = 0; td[2] = 0;
        @(negedge clk);
        start = 1'b1;
        t0 = cyc + 1;
        for (int k = 0; k < 3 * (lat + 2) + 20; k++) begin
            @(negedge clk);
            if (ld_m === 1'b1) begin
                loads++;
                if (loads == 3) start = 1'b0;
            end
            if (done === 1'b1) begin
                td[d] = cyc;
                ep = exp_prod.pop_front();
                void'(exp_lat.pop_front());
                n_checks++;
                if ({dp_a, dp_q} !== ep) begin
                    n_fail++;
                    $display("FAIL b2b_product[%0d]: got %h want %h", d, {dp_a, dp_q}, ep);
                end
                d++;
                if (d == 3) break;
            end
            if (d >= 1 && d <= 2 && busy === 1'b0) low[d-1]++;
        end
        start = 1'b0;
        n_checks++;
        if (d != 3) begin
            n_fail++;
            $display("FAIL b2b_done_count: got %0d want 3", d);
        end else begin
            n_checks++;
            if (td[0] - t0 != lat) begin
                n_fail++;
                $display("FAIL b2b_first_latency: got %0d want %0d", td[0] - t0, lat);
            end
            n_checks++;
            if (td[1] - td[0] != lat + 2 || td[2] - td[1] != lat + 2) begin
                n_fail++;
                $display("FAIL b2b_spacing: got %0d %0d want %0d", td[1] - td[0], td[2] - td[1], lat + 2);
            end
            n_checks++;
            if (low[0] != 2 || low[1] != 2) begin
                n_fail++;
                $display("FAIL b2b_busy_gap: got %0d %0d want 2 2", low[0], low[1]);
            end
        end
        repeat (4) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || n_done != 3 || excl_err != 0) begin
            n_fail++;
            $display("FAIL b2b_final: got busy=%b done=%0d excl=%0d want 0 3 0", busy, n_done, excl_err);
        end
    endtask

`ifdef BOOTH_SEQ_SKIP_EN
    task automatic test_skip();
        int t0, td;
        bit ok;
        logic [W-1:0] ms[2];
        ms[0] = 16'h0000;
        ms[1] = 16'h8000;
        for (int j = 0; j < 2; j++) begin
            repeat (3) @(negedge clk);
            mcand = 16'sd99;
            mplier = ms[j];
            exp_prod.push_back(ref_prod(mcand, mplier));
            exp_lat.push_back(exp_latency(mplier));
            clear_counts();
            start_pulse(t0);
            wait_done(80, td, ok);
            n_checks++;
            if (!ok) begin
                n_fail++;
                $display("FAIL skip_done_timeout[%0d]: got no done want done", j);
            end else begin
                n_checks++;
                if ({dp_a, dp_q} !== exp_prod.pop_front()) begin
                    n_fail++;
                    $display("FAIL skip_product[%0d]: got %h", j, {dp_a, dp_q});
                end
                n_checks++;
                if (td - t0 != exp_lat.pop_front() || n_shift != W ||
                    n_sub != j || n_add != 0) begin
                    n_fail++;
                    $display("FAIL skip_profile[%0d]: got lat=%0d shift=%0d sub=%0d add=%0d",
                             j, td - t0, n_shift, n_sub, n_add);
                end
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_alternating();
        test_ignore_start();
        test_back_to_back();
`ifdef BOOTH_SEQ_SKIP_EN
        test_skip();
`endif
        n_checks++;
        if (exp_prod.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d left want 0", exp_prod.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
